ui_input_conditioner: RTL and testbench
=======================================

Name: ui_input_conditioner

Overview:
Sits between the raw ui_in pins and speed_controller in tt_um_watpixels. It synchronises and debounces all eight user inputs. It emits single-cycle pause/resume pulses and a held run state, and it priority-encodes the speed buttons into a 3-bit speed. The speed is applied only at frame_start, so pattern speed never changes mid-frame.

Parameters:
DEBOUNCE_CYCLES, 250000, clk cycles between debounce sample ticks (10 ms at 25 MHz); minimum 2
SYNC_STAGES, 2, synchroniser flops per input bit; minimum 2

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
ui_in  input  8  raw buttons: [0] pause, [1] resume, [2] speed_1 (unused, implicit default), [7:3] speed_2..speed_6
frame_start  input  1  one-cycle pulse from vga_timing at start of frame
pause_pulse  output  1  one-cycle pulse on debounced pause rising edge
resume_pulse  output  1  one-cycle pulse on debounced resume rising edge
running  output  1  1 = animation running, 0 = paused
speed  output  3  applied speed, 1..6
speed_pending  output  3  debounced encoded speed awaiting frame_start

Behaviour:
- Reset (rst_n=0, async): all synchroniser flops, histories, debounced bits and prescaler go to 0; pause_pulse=0, resume_pulse=0, running=1, speed=1, speed_pending=1.
- Synchroniser: per bit, SYNC_STAGES-deep flop chain; sync[i] is the last stage.
- Prescaler: counter 0..DEBOUNCE_CYCLES-1, width $clog2(DEBOUNCE_CYCLES). tick=1 for one cycle when the count equals DEBOUNCE_CYCLES-1, then the counter wraps to 0.
- Debounce, per bit, on tick only:
  - shift sync[i] into a 2-bit history;
  - db[i] <= sync[i] if both history bits already equal sync[i] (three consecutive equal samples); otherwise db[i] holds.
- Debounce guarantees:
  - a pulse shorter than DEBOUNCE_CYCLES never changes db;
  - a level held stable changes db no later than SYNC_STAGES + 3*DEBOUNCE_CYCLES cycles after the pin change.
- Edge detect: db_prev registered every cycle.
  - pause_pulse = registered (db[0] & ~db_prev[0]); resume_pulse likewise for bit 1.
  - Each pulse is exactly 1 cycle, one cycle after db rises. Falling edges produce nothing.
- Simultaneous rising edges of pause and resume in the same cycle: pause wins. pause_pulse=1, resume_pulse=0.
- running (without the optional feature):
  - cleared the cycle after pause_pulse;
  - set the cycle after resume_pulse;
  - otherwise holds.
- Speed encode, combinational from db: db[7]->6, else db[6]->5, else db[5]->4, else db[4]->3, else db[3]->2, else 1. Registered into speed_pending every cycle.
- Speed apply: speed <= speed_pending on any cycle with frame_start=1, visible the cycle after.
  - frame_start coinciding with a speed_pending change latches the old speed_pending value; the new value applies at the next frame_start.
- Reset mid-operation: the prescaler phase restarts and pending debounces are discarded. No pulse is emitted on reset release, even if buttons are held, because db and db_prev both start at 0 and db needs three ticks to rise.
- Outputs are all registered; no combinational path from ui_in or frame_start to any output.

Optional Feature:
Macro UI_COND_TOGGLE_EN.
- Defined: pause_pulse toggles running. resume_pulse forces running=1. When both occur together, resume_pulse is suppressed per the priority rule, so only the toggle applies.
- Undefined: the set/clear behaviour above, with no toggle logic synthesised.

Test Plan:
- DEBOUNCE_CYCLES=4, reset then idle 100 cycles -> running=1, speed=1, speed_pending=1, no pulses.
- Hold ui_in[0]=1 for 40 cycles -> exactly one pause_pulse within 2+12+1 cycles of the rise; running=0 the following cycle; no pulse on release.
- Glitch ui_in[1]=1 for 3 cycles, repeated at random phase 50 times -> resume_pulse never asserts; running unchanged.
- Hold ui_in[7]=1 and ui_in[3]=1 -> speed_pending=6. speed stays 1 until the next frame_start, then equals 6 one cycle later. Release both and pulse frame_start -> speed=1.
- Raise ui_in[0] and ui_in[1] in the same cycle while running=1 -> pause_pulse=1, resume_pulse=0, running=0. With UI_COND_TOGGLE_EN, a second pause press -> running=1.
- Assert rst_n=0 for 1 cycle mid-debounce while ui_in[4]=1, then hold 40 cycles -> speed_pending=1 immediately after reset, becomes 3 after three ticks; pause_pulse and resume_pulse stay 0 throughout.

Source files
------------

// File: rtl/ui_input_conditioner_if.sv
// ui_input_conditioner_if
//   Groups the button/frame inputs and the conditioned control outputs of
//   ui_input_conditioner.
//   master : drives ui_in/frame_start, observes the conditioned outputs
//   slave  : the conditioner itself
//   Signals:
//     ui_in         [7:0] raw buttons ([0] pause, [1] resume, [2] speed_1,
//                         [7:3] speed_2..speed_6)
//     frame_start         one-cycle start-of-frame pulse
//     pause_pulse         one-cycle pulse on debounced pause press
//     resume_pulse        one-cycle pulse on debounced resume press
//     running             1 = animation running
//     speed         [2:0] applied speed (1..6)
//     speed_pending [2:0] debounced speed waiting for frame_start
interface ui_input_conditioner_if;
   logic [7:0] ui_in;
   logic       frame_start;
   logic       pause_pulse;
   logic       resume_pulse;
   logic       running;
   logic [2:0] speed;
   logic [2:0] speed_pending;

   modport master (
      output ui_in, frame_start,
      input  pause_pulse, resume_pulse, running, speed, speed_pending
   );

   modport slave (
      input  ui_in, frame_start,
      output pause_pulse, resume_pulse, running, speed, speed_pending
   );
endinterface

// File: rtl/ui_input_conditioner.sv
// ui_input_conditioner
//   Synchronises and debounces the eight user buttons, produces single-cycle
//   pause/resume pulses and a held run state, and priority-encodes the speed
//   buttons into a 3-bit speed that only changes at frame_start.
//   Optional feature macro: UI_COND_TOGGLE_EN (pause toggles running,
//   resume forces running=1). Without it pause clears and resume sets.
//   Ports:
//     clk   : pixel clock
//     rst_n : asynchronous active-low reset
//     bus   : ui_input_conditioner_if.slave (ui_in, frame_start in;
//             pause_pulse, resume_pulse, running, speed, speed_pending out)
//   Parameters:
//     DEBOUNCE_CYCLES : clk cycles between debounce sample ticks (>= 2)
//     SYNC_STAGES     : synchroniser depth per input bit (>= 2)
module ui_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input logic                     clk,
   input logic                     rst_n,
   ui_input_conditioner_if.slave   bus
);

   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [7:0]       sync_q [SYNC_STAGES];
   logic [7:0]       sync;
   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic [7:0]       hist_new;
   logic [7:0]       hist_old;
   logic [7:0]       db;
   logic [7:0]       settled;
   logic [1:0]       db_prev;
   logic             pause_rise;
   logic             resume_rise;
   logic [2:0]       speed_enc;

   logic             pause_pulse_q;
   logic             resume_pulse_q;
   logic             running_q;
   logic [2:0]       speed_q;
   logic [2:0]       speed_pending_q;

   // ---------------- synchroniser ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= bus.ui_in;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // ---------------- prescaler ----------------
   assign tick = (cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + CNT_W'(1);
   end

   // ---------------- debounce ----------------
   // A bit is settled when both history samples already match the current
   // synchronised value, i.e. three consecutive equal ticks.
   assign settled = ~(hist_new ^ sync) & ~(hist_old ^ sync);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_new <= '0;
         hist_old <= '0;
         db       <= '0;
      end else if (tick) begin
         hist_old <= hist_new;
         hist_new <= sync;
         db       <= (settled & sync) | (~settled & db);
      end
   end

   // ---------------- edge detect / run state ----------------
   assign pause_rise  = db[0] & ~db_prev[0];
   // Pause has priority when both buttons rise in the same cycle.
   assign resume_rise = db[1] & ~db_prev[1] & ~pause_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_prev        <= '0;
         pause_pulse_q  <= 1'b0;
         resume_pulse_q <= 1'b0;
         running_q      <= 1'b1;
      end else begin
         db_prev        <= db[1:0];
         pause_pulse_q  <= pause_rise;
         resume_pulse_q <= resume_rise;
`ifdef UI_COND_TOGGLE_EN
         if (pause_pulse_q)       running_q <= ~running_q;
         else if (resume_pulse_q) running_q <= 1'b1;
`else
         if (pause_pulse_q)       running_q <= 1'b0;
         else if (resume_pulse_q) running_q <= 1'b1;
`endif
      end
   end

   // ---------------- speed encode / apply ----------------
   // db[2] (speed_1) maps to the same value as "no button": speed 1.
   always_comb begin
      speed_enc = 3'd1;
      if (db[7])      speed_enc = 3'd6;
      else if (db[6]) speed_enc = 3'd5;
      else if (db[5]) speed_enc = 3'd4;
      else if (db[4]) speed_enc = 3'd3;
      else if (db[3]) speed_enc = 3'd2;
      else if (db[2]) speed_enc = 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         speed_pending_q <= 3'd1;
         speed_q         <= 3'd1;
      end else begin
         speed_pending_q <= speed_enc;
         // Latches the registered pending value, so a change landing in the
         // same cycle as frame_start waits for the next frame.
         if (bus.frame_start) speed_q <= speed_pending_q;
      end
   end

   assign bus.pause_pulse   = pause_pulse_q;
   assign bus.resume_pulse  = resume_pulse_q;
   assign bus.running       = running_q;
   assign bus.speed         = speed_q;
   assign bus.speed_pending = speed_pending_q;

endmodule

// File: tb/tb_ui_input_conditioner.sv
// tb_ui_input_conditioner
//   Directed bench for ui_input_conditioner with DEBOUNCE_CYCLES=4 and
//   SYNC_STAGES=2. Expected pulses are queued by the stimulus and consumed
//   by a monitor whenever the DUT emits a pause or resume pulse.
module tb_ui_input_conditioner;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   ui_input_conditioner_if bus ();

   ui_input_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .SYNC_STAGES     (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic p;
      logic r;
   } pulse_t;

   pulse_t exp_q[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Waits up to 20 cycles for the selected pulse; n=99 when it never comes.
   task automatic wait_pulse(input bit resume, output int n);
      n = 99;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if ((resume ? bus.resume_pulse : bus.pause_pulse) == 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   // Scoreboard monitor: every emitted pulse must match the queue head.
   always @(negedge clk) begin
      if (rst_n && (bus.pause_pulse || bus.resume_pulse)) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse: got pause=%0b resume=%0b expected none",
                     bus.pause_pulse, bus.resume_pulse);
         end else begin
            pulse_t e;
            e = exp_q.pop_front();
            if (bus.pause_pulse !== e.p || bus.resume_pulse !== e.r) begin
               failures++;
               $display("FAIL pulse_kind: got pause=%0b resume=%0b expected pause=%0b resume=%0b",
                        bus.pause_pulse, bus.resume_pulse, e.p, e.r);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   int n;

   initial begin
      bus.ui_in       = '0;
      bus.frame_start = 1'b0;
      rst_n           = 1'b0;
      cyc(3);
      check("reset_running", bus.running, 1);
      check("reset_speed", bus.speed, 1);
      check("reset_pending", bus.speed_pending, 1);
      check("reset_pause", bus.pause_pulse, 0);
      rst_n = 1'b1;

      // Idle
      cyc(100);
      check("idle_running", bus.running, 1);
      check("idle_speed", bus.speed, 1);
      check("idle_pending", bus.speed_pending, 1);

      // Pause press held 40 cycles
      exp_q.push_back('{p: 1'b1, r: 1'b0});
      bus.ui_in[0] = 1'b1;
      wait_pulse(1'b0, n);
      check_range("pause_latency", n, 12, 15);
      cyc(1);
      check("pause_width", bus.pause_pulse, 0);
      check("running_after_pause", bus.running, 0);
      cyc(40 - n - 1);
      bus.ui_in[0] = 1'b0;
      cyc(40);
      check("running_after_release", bus.running, 0);

      // Resume press restores running
      exp_q.push_back('{p: 1'b0, r: 1'b1});
      bus.ui_in[1] = 1'b1;
      wait_pulse(1'b1, n);
      check_range("resume_latency", n, 12, 15);
      cyc(1);
      check("running_after_resume", bus.running, 1);
      cyc(30);
      bus.ui_in[1] = 1'b0;
      cyc(40);

      // Short glitches on resume never debounce
      for (int g = 0; g < 50; g++) begin
         bus.ui_in[1] = 1'b1;
         cyc(3);
         bus.ui_in[1] = 1'b0;
         cyc($urandom_range(5, 12));
      end
      cyc(20);
      check("running_after_glitches", bus.running, 1);

      // Speed buttons: 7 beats 3
      bus.ui_in[7] = 1'b1;
      bus.ui_in[3] = 1'b1;
      cyc(40);
      check("pending_6", bus.speed_pending, 6);
      check("speed_before_frame", bus.speed, 1);
      bus.frame_start = 1'b1;
      cyc(1);
      bus.frame_start = 1'b0;
      check("speed_after_frame", bus.speed, 6);
      bus.ui_in[7] = 1'b0;
      bus.ui_in[3] = 1'b0;
      cyc(40);
      check("pending_back_1", bus.speed_pending, 1);
      check("speed_held_6", bus.speed, 6);
      bus.frame_start = 1'b1;
      cyc(1);
      bus.frame_start = 1'b0;
      check("speed_back_1", bus.speed, 1);

      // frame_start coinciding with a pending change latches the old value
      bus.frame_start = 1'b1;
      bus.ui_in[5]    = 1'b1;
      n = 99;
      for (int i = 1; i <= 30; i++) begin
         cyc(1);
         if (bus.speed_pending == 3'd4) begin
            n = i;
            break;
         end
      end
      check_range("pending_4_latency", n, 1, 30);
      check("speed_old_at_change", bus.speed, 1);
      cyc(1);
      check("speed_new_next_frame", bus.speed, 4);
      bus.frame_start = 1'b0;
      bus.ui_in[5]    = 1'b0;
      cyc(40);

      // Simultaneous pause and resume: pause wins
      exp_q.push_back('{p: 1'b1, r: 1'b0});
      bus.ui_in[1:0] = 2'b11;
      wait_pulse(1'b0, n);
      check_range("both_latency", n, 12, 15);
      check("both_resume_low", bus.resume_pulse, 0);
      cyc(1);
      check("both_running", bus.running, 0);
      cyc(30);
      bus.ui_in[1:0] = 2'b00;
      cyc(40);

`ifdef UI_COND_TOGGLE_EN
      exp_q.push_back('{p: 1'b1, r: 1'b0});
      bus.ui_in[0] = 1'b1;
      wait_pulse(1'b0, n);
      cyc(1);
      check("toggle_running", bus.running, 1);
      cyc(30);
      bus.ui_in[0] = 1'b0;
`else
      exp_q.push_back('{p: 1'b0, r: 1'b1});
      bus.ui_in[1] = 1'b1;
      wait_pulse(1'b1, n);
      cyc(1);
      check("resume2_running", bus.running, 1);
      cyc(30);
      bus.ui_in[1] = 1'b0;
`endif
      cyc(40);

      // Reset mid-debounce with speed_3 held
      bus.ui_in[4] = 1'b1;
      cyc(6);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_pending", bus.speed_pending, 1);
      check("midrst_speed", bus.speed, 1);
      check("midrst_running", bus.running, 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("postrst_pending", bus.speed_pending, 1);
      cyc(10);
      check("postrst_pending_early", bus.speed_pending, 1);
      cyc(30);
      check("postrst_pending_3", bus.speed_pending, 3);
      bus.ui_in[4] = 1'b0;
      cyc(20);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
